// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the MIPS register file slice: register count,
// hard-wired zero register index, stack-pointer register index and the
// native word width.
package mips_pkg;

   localparam int REG_COUNT  = 32;
   localparam int ZERO_REG   = 0;
   localparam int SP_REG     = 29;
   localparam int WORD_WIDTH = 32;

endpackage : mips_pkg

// File: rtl/mips_register_file_decoder.sv
// decoder_5_to_32
// Write-enable generator for the register file. Produces a one-hot select
// from the destination address, gated by the write enable. The zero
// register's select is forced low so writes to it vanish.
//
// Ports
//   i_addr  : destination register address
//   i_en    : write enable (reg_write)
//   o_we    : one-hot per-register write strobe
module decoder_5_to_32
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0]      i_addr,
   input  logic                       i_en,
   output logic [(1<<ADDR_WIDTH)-1:0] o_we
);

   always_comb begin
      o_we = '0;
      if (i_en) begin
         o_we[i_addr] = 1'b1;
      end
      o_we[ZERO_REG] = 1'b0;
   end

endmodule : decoder_5_to_32

// File: rtl/mips_register_file_mux.sv
// mux_32_to_1
// Combinational word selector used for each read port. Selects one of
// 2**SEL_WIDTH words of DATA_WIDTH bits by index.
//
// Ports
//   i_words : flattened bank of words, index 0 at the low end
//   i_sel   : word index
//   o_data  : selected word
module mux_32_to_1 #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 5
) (
   input  logic [(1<<SEL_WIDTH)-1:0][DATA_WIDTH-1:0] i_words,
   input  logic [SEL_WIDTH-1:0]                      i_sel,
   output logic [DATA_WIDTH-1:0]                     o_data
);

   assign o_data = i_words[i_sel];

endmodule : mux_32_to_1

// File: rtl/mips_register_file.sv
// mips_register_file
// Two-read, one-write MIPS general-purpose register file. Reads are
// combinational with no write-to-read bypass (a read of the register being
// written returns the old value). Register 0 is hard-wired to zero.
// Synchronous active-high reset clears all registers except $sp, which
// loads SP_INIT.
//
// Ports
//   clock       : rising-edge clock
//   reset       : synchronous active-high reset, wins over a write
//   read_reg_1  : rs address          -> read_data_1
//   read_reg_2  : rt address          -> read_data_2
//   write_reg   : destination address
//   write_data  : write-back value
//   reg_write   : write enable
module mips_register_file
   import mips_pkg::*;
#(
   parameter int                    DATA_WIDTH = WORD_WIDTH,
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0FFC
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg_1,
   input  logic [ADDR_WIDTH-1:0] read_reg_2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [NUM_REGS-1:0]                 w_we;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;

   decoder_5_to_32 #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_we_dec (
      .i_addr (write_reg),
      .i_en   (reg_write),
      .o_we   (w_we)
   );

   // The zero register has no storage, so it reads 0 even before the
   // first reset.
   assign w_regs[ZERO_REG] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      localparam logic [DATA_WIDTH-1:0] RST_VAL = (i == SP_REG) ? SP_INIT : '0;

      logic [DATA_WIDTH-1:0] r_word;

      always_ff @(posedge clock) begin
         if (reset) begin
            r_word <= RST_VAL;
         end else if (w_we[i]) begin
            r_word <= write_data;
         end
      end

      assign w_regs[i] = r_word;
   end

   mux_32_to_1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (ADDR_WIDTH)
   ) u_rd_mux_1 (
      .i_words (w_regs),
      .i_sel   (read_reg_1),
      .o_data  (read_data_1)
   );

   mux_32_to_1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (ADDR_WIDTH)
   ) u_rd_mux_2 (
      .i_words (w_regs),
      .i_sel   (read_reg_2),
      .o_data  (read_data_2)
   );

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: reset sweep, a directed
// vector table, and a hand-written fill/readback sequence.
module tb_mips_register_file;

   logic        clock;
   logic        reset;
   logic [4:0]  read_reg_1;
   logic [4:0]  read_reg_2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;

   int n_cmp;
   int n_err;

   localparam logic [31:0] SP_RST = 32'h0000_0FFC;

   mips_register_file dut (
      .clock       (clock),
      .reset       (reset),
      .read_reg_1  (read_reg_1),
      .read_reg_2  (read_reg_2),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .reg_write   (reg_write),
      .read_data_1 (read_data_1),
      .read_data_2 (read_data_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are driven just after a rising edge, outputs sampled on the
   // falling edge (before the next write commits), then the edge is taken.
   task automatic step(input logic rst, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic [4:0] rr1,
                       input logic [4:0] rr2, input logic [31:0] e1,
                       input logic [31:0] e2, input string name);
      reset      = rst;
      reg_write  = we;
      write_reg  = wreg;
      write_data = wdata;
      read_reg_1 = rr1;
      read_reg_2 = rr2;
      @(negedge clock);
      chk({name, "/rd1"}, read_data_1, e1);
      chk({name, "/rd2"}, read_data_2, e2);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      n_cmp = 0;
      n_err = 0;
      reset      = 1'b1;
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      read_reg_1 = '0;
      read_reg_2 = '0;
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset sweep over all addresses on both ports.
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = 5'(i);
         read_reg_2 = 5'(31 - i);
         #1;
         exp_a = (i == 29) ? SP_RST : 32'h0;
         exp_b = ((31 - i) == 29) ? SP_RST : 32'h0;
         chk($sformatf("rst_sweep_p1_r%0d", i), read_data_1, exp_a);
         chk($sformatf("rst_sweep_p2_r%0d", 31 - i), read_data_2, exp_b);
      end

      //                rst   we    wreg   wdata          rr1    rr2    e1             e2
      vecs.push_back('{1'b0, 1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  32'h0,         32'h0});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd8,  5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd8,  32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0});
      vecs.push_back('{1'b0, 1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd8,  32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd8,  32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd8,  32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd29, 32'h0,         SP_RST});
      vecs.push_back('{1'b0, 1'b1, 5'd29, 32'h1111_2222, 5'd29, 5'd0,  SP_RST,        32'h0});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd29, 5'd29, 32'h1111_2222, 32'h1111_2222});
      vecs.push_back('{1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd8,  32'h0,         32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd8,  32'h0,         32'h0});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         5'd29, 5'd29, SP_RST,        SP_RST});

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].we, vecs[k].wreg, vecs[k].wdata,
              vecs[k].rr1, vecs[k].rr2, vecs[k].e1, vecs[k].e2,
              $sformatf("vec%0d", k));
      end

      // Fill r1..r31 on consecutive edges. Port 1 watches the target
      // (old value this cycle), port 2 the previous target (just written).
      for (int i = 1; i < 32; i++) begin
         exp_a = (i == 29) ? SP_RST : 32'h0;
         exp_b = 32'(i - 1) * 32'h0101_0101;
         step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(i - 1),
              exp_a, exp_b, $sformatf("fill_r%0d", i));
      end

      // Readback of every register on both ports with different addresses.
      reg_write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = 5'(i);
         read_reg_2 = 5'((i + 7) % 32);
         #1;
         exp_a = 32'(i) * 32'h0101_0101;
         exp_b = 32'((i + 7) % 32) * 32'h0101_0101;
         chk($sformatf("readback_p1_r%0d", i), read_data_1, exp_a);
         chk($sformatf("readback_p2_r%0d", (i + 7) % 32), read_data_2, exp_b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mips_register_file

// File: doc/mips_register_file.md
MIPS_REGISTER_FILE -- requirements
Module: mips_register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5: register-address width, giving 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have parameter SP_INIT, default 32'h0000_0FFC: reset value of register 29 ($sp).
REQ-004 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port read_reg_1, input, ADDR_WIDTH bits: rs address.
REQ-007 The block SHALL have port read_reg_2, input, ADDR_WIDTH bits: rt address.
REQ-008 The block SHALL have port write_reg, input, ADDR_WIDTH bits: destination address, driven by the RegDst 2:1 mux.
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH bits: write-back value, driven by the MemtoReg 2:1 32-bit mux.
REQ-010 The block SHALL have port reg_write, input, 1 bit: write enable.
REQ-011 The block SHALL have port read_data_1, output, DATA_WIDTH bits: contents of register read_reg_1.
REQ-012 The block SHALL have port read_data_2, output, DATA_WIDTH bits: contents of register read_reg_2.

Function
REQ-013 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-014 Reads SHALL be combinational: zero-cycle latency from an address change to the output, and a read always returns the stored value.
REQ-015 When reg_write=1, reset=0 and write_reg!=0, the block SHALL load write_data into register write_reg on the rising clock edge; all other registers are unchanged.
REQ-016 Written data SHALL be visible on the read ports in the cycle after the write edge (one-cycle write latency).
REQ-017 A read of the register being written in the same cycle SHALL return the old value; there is no write-to-read bypass, which avoids a combinational loop through the ALU and write-back mux.
REQ-018 Register 0 SHALL always read 0; a write to address 0 SHALL be discarded with no side effect.
REQ-019 When read_reg_1 equals read_reg_2, both outputs SHALL return identical data.
REQ-020 When reg_write=0, no register SHALL change, regardless of write_reg and write_data.
REQ-021 Address X/Z SHALL NOT be handled; the team's simulation checks cover it.

Reset
REQ-022 On a rising edge with reset=1, every register SHALL clear to 0 except register 29, which SHALL load SP_INIT.
REQ-023 Reset SHALL take precedence over a simultaneous write; that write is lost.
REQ-024 Reset asserted in the middle of a program SHALL take effect at the next edge, and read outputs SHALL reflect the reset values in the following cycle.
REQ-025 After reset, read_data_1 and read_data_2 SHALL be 0 for every address except 29.

Structure
REQ-026 The shared package mips_pkg SHALL hold the constants REG_COUNT=32, ZERO_REG=0, SP_REG=29 and WORD_WIDTH=32.
REQ-027 Write-enable generation SHALL be a single sub-module, decoder_5_to_32 (one-hot write select, gated by reg_write, with bit 0 forced low).
REQ-028 The read paths SHALL be two instances of one 32:1 DATA_WIDTH-bit selection structure.

Verification
REQ-029 The bench SHALL apply reset for 1 cycle, then sweep read_reg_1 and read_reg_2 over 0-31; all reads return 0 except address 29, which returns 32'h0000_0FFC.
REQ-030 The bench SHALL write 32'hDEAD_BEEF to register 8 with reg_write=1, then read register 8 on both ports in the next cycle; both return 32'hDEAD_BEEF, and in the write cycle itself the old value 0 is returned.
REQ-031 The bench SHALL write 32'hFFFF_FFFF to register 0, then read register 0; the read returns 0.
REQ-032 The bench SHALL hold reg_write=0 with write_reg=5 and write_data=32'h1234_5678 for 3 cycles; register 5 stays 0.
REQ-033 The bench SHALL write 32'hA5A5_A5A5 to register 31 with reset=1 in the same edge; register 31 reads 0 afterwards.
REQ-034 The bench SHALL write r(i)=i*32'h0101_0101 for i=1..31 on consecutive edges, then read all registers back; every value matches, confirming no aliasing across registers.
